// File: rtl/branch_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the main control FSM / PC-ALU
// datapath (master) and the branch sequencer (slave).
interface branch_seq_ctrl_if;
  logic        start;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic        alu_gt;
  logic [31:0] alu_result;
  logic        busy;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        target_we;
  logic [1:0]  branch_sel;
  logic        pc_write;
  logic        done;
  logic        taken;

  modport master (
    output start, branch_op, alu_zero, alu_gt, alu_result,
    input  busy, alu_src_a, alu_src_b, alu_op, target_we, branch_sel,
           pc_write, done, taken
  );

  modport slave (
    input  start, branch_op, alu_zero, alu_gt, alu_result,
    output busy, alu_src_a, alu_src_b, alu_op, target_we, branch_sel,
           pc_write, done, taken
  );
endinterface

// File: rtl/branch_seq_ctrl.sv
// Multicycle branch sequencer: owns the shared ALU for a conditional branch,
// computes the target (PC + offset<<2), then compares rs/rt and resolves.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_seq_ctrl #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  branch_seq_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_taken
`endif
);

  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TARGET, S_T_WAIT, S_CMP, S_C_WAIT, S_RESOLVE
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  op_q;
  logic        busy_q;
  logic        src_a_q;
  logic [1:0]  src_b_q;
  logic [2:0]  alu_op_q;
  logic        target_we_q;
  logic        pc_write_q;
  logic        done_q;
  logic        taken_q;
  logic        cond;

  // Branch condition from the ALU flags, selected by the latched opcode.
  always_comb begin
    cond = 1'b0;
    unique case (op_q)
      2'b00:   cond = bus.alu_zero;
      2'b01:   cond = ~bus.alu_zero;
      2'b10:   cond = bus.alu_gt;
      default: cond = ~bus.alu_gt;
    endcase
  end

  // Sequencer FSM; outputs are registered, so each transition loads the
  // output values belonging to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      busy_q      <= 1'b0;
      src_a_q     <= 1'b0;
      src_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      target_we_q <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      target_we_q <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      taken_q     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q     <= bus.branch_op;
            busy_q   <= 1'b1;
            src_a_q  <= 1'b0;
            src_b_q  <= 2'b11;
            alu_op_q <= OP_ADD;
            state    <= S_TARGET;
          end
        end
        S_TARGET: begin
          cnt         <= CNT_INIT;
          target_we_q <= (CNT_INIT == '0);
          state       <= S_T_WAIT;
        end
        S_T_WAIT: begin
          if (cnt == '0) begin
            src_a_q  <= 1'b1;
            src_b_q  <= 2'b00;
            alu_op_q <= OP_SUB;
            state    <= S_CMP;
          end else begin
            cnt         <= cnt - 3'd1;
            // Write strobe lands in the T_WAIT cycle whose count reaches zero.
            target_we_q <= (cnt == 3'd1);
          end
        end
        S_CMP: begin
          cnt   <= CNT_INIT;
          state <= S_C_WAIT;
        end
        S_C_WAIT: begin
          if (cnt == '0) begin
            done_q     <= 1'b1;
            taken_q    <= cond;
            pc_write_q <= cond;
            src_a_q    <= 1'b0;
            src_b_q    <= 2'b00;
            alu_op_q   <= OP_ADD;
            state      <= S_RESOLVE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters of resolved and taken branches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (done_q) begin
      if (stat_total != '1) stat_total <= stat_total + 1'b1;
      if (taken_q && (stat_taken != '1)) stat_taken <= stat_taken + 1'b1;
    end
  end
`endif

  assign bus.busy       = busy_q;
  assign bus.alu_src_a  = src_a_q;
  assign bus.alu_src_b  = src_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.target_we  = target_we_q;
  assign bus.branch_sel = op_q;
  assign bus.pc_write   = pc_write_q;
  assign bus.done       = done_q;
  assign bus.taken      = taken_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl with ALU_LAT=1 and ALU_LAT=3 instances.
module tb_branch_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_seq_ctrl_if bi1 ();
  branch_seq_ctrl_if bi3 ();

`ifdef BRANCH_STATS_EN
  logic [1:0]  st1_total, st1_taken;
  logic [15:0] st3_total, st3_taken;
`endif

  branch_seq_ctrl #(.ALU_LAT(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bi1)
`ifdef BRANCH_STATS_EN
    , .stat_total(st1_total), .stat_taken(st1_taken)
`endif
  );

  branch_seq_ctrl #(.ALU_LAT(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bi3)
`ifdef BRANCH_STATS_EN
    , .stat_total(st3_total), .stat_taken(st3_taken)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit use3, input logic s, input logic [1:0] o,
                       input logic z, input logic g);
    if (use3) begin
      bi3.start = s; bi3.branch_op = o; bi3.alu_zero = z; bi3.alu_gt = g;
    end else begin
      bi1.start = s; bi1.branch_op = o; bi1.alu_zero = z; bi1.alu_gt = g;
    end
  endtask

  // One branch from the current negedge (cycle 0); bit k of each vector is
  // the output value observed in cycle k. Opcode is inverted while busy.
  task automatic run_br(input bit use3, input logic [1:0] op,
                        input logic [15:0] zpat, input logic [15:0] gpat,
                        output logic [15:0] twe_v, output logic [15:0] busy_v,
                        output logic [15:0] done_v, output logic [15:0] pcw_v,
                        output logic [15:0] tkn_v, output logic [15:0] srca_v,
                        output logic [15:0] sub_v, output logic [15:0] srcb_v,
                        output int sel_bad);
    twe_v = '0; busy_v = '0; done_v = '0; pcw_v = '0; tkn_v = '0;
    srca_v = '0; sub_v = '0; srcb_v = '0; sel_bad = 0;
    drive(use3, 1'b1, op, zpat[0], gpat[0]);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (use3) begin
        twe_v[k] = bi3.target_we; busy_v[k] = bi3.busy; done_v[k] = bi3.done;
        pcw_v[k] = bi3.pc_write;  tkn_v[k] = bi3.taken;  srca_v[k] = bi3.alu_src_a;
        sub_v[k] = (bi3.alu_op == 3'b110); srcb_v[k] = (bi3.alu_src_b == 2'b11);
        if (bi3.branch_sel !== op) sel_bad++;
      end else begin
        twe_v[k] = bi1.target_we; busy_v[k] = bi1.busy; done_v[k] = bi1.done;
        pcw_v[k] = bi1.pc_write;  tkn_v[k] = bi1.taken;  srca_v[k] = bi1.alu_src_a;
        sub_v[k] = (bi1.alu_op == 3'b110); srcb_v[k] = (bi1.alu_src_b == 2'b11);
        if (bi1.branch_sel !== op) sel_bad++;
      end
      drive(use3, 1'b0, ~op, zpat[k], gpat[k]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] twe, bsy, dn, pcw, tkn, sra, sub, srb;
    int sel_bad, ndone, npcw;
    logic [1:0] sel7, sel3;

    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    bi1.alu_result = 32'h0000_1000;
    bi3.alu_result = 32'h0000_2000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_alu_op", 32'(bi1.alu_op), 32'h2);
    chk("rst_busy", 32'(bi1.busy), 32'h0);
    chk("rst_sel", 32'(bi1.branch_sel), 32'h0);
    chk("rst_done3", 32'(bi3.done), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // BEQ taken, ALU_LAT=1
    run_br(1'b0, 2'b00, 16'hFFFF, 16'h0000, twe, bsy, dn, pcw, tkn, sra, sub, srb, sel_bad);
    chk("beq_twe", 32'(twe), 32'h0004);
    chk("beq_busy", 32'(bsy), 32'h003E);
    chk("beq_done", 32'(dn), 32'h0020);
    chk("beq_pcw", 32'(pcw), 32'h0020);
    chk("beq_taken", 32'(tkn), 32'h0020);
    chk("beq_srca", 32'(sra), 32'h0018);
    chk("beq_sub", 32'(sub), 32'h0018);
    chk("beq_srcb", 32'(srb), 32'h0006);
    chk("beq_sel", 32'(sel_bad), 32'h0);

    // BNE not taken, ALU_LAT=1
    run_br(1'b0, 2'b01, 16'hFFFF, 16'h0000, twe, bsy, dn, pcw, tkn, sra, sub, srb, sel_bad);
    chk("bne_twe", 32'(twe), 32'h0004);
    chk("bne_done", 32'(dn), 32'h0020);
    chk("bne_pcw", 32'(pcw), 32'h0000);
    chk("bne_taken", 32'(tkn), 32'h0000);
    chk("bne_sel", 32'(sel_bad), 32'h0);

    // BLE taken, ALU_LAT=3, alu_gt glitching in cycles 6..7
    run_br(1'b1, 2'b11, 16'h0000, 16'h00C0, twe, bsy, dn, pcw, tkn, sra, sub, srb, sel_bad);
    chk("ble_twe", 32'(twe), 32'h0010);
    chk("ble_busy", 32'(bsy), 32'h03FE);
    chk("ble_done", 32'(dn), 32'h0200);
    chk("ble_pcw", 32'(pcw), 32'h0200);
    chk("ble_taken", 32'(tkn), 32'h0200);
    chk("ble_srca", 32'(sra), 32'h01E0);
    chk("ble_srcb", 32'(srb), 32'h001E);
    chk("ble_sel", 32'(sel_bad), 32'h0);

    // BGT not taken, ALU_LAT=3, alu_gt high until the final C_WAIT cycle
    run_br(1'b1, 2'b10, 16'h0000, 16'h00FF, twe, bsy, dn, pcw, tkn, sra, sub, srb, sel_bad);
    chk("bgt_done", 32'(dn), 32'h0200);
    chk("bgt_pcw", 32'(pcw), 32'h0000);

    // Start held high, op cycling: accepted at cycles 0, 6, 12
    ndone = 0; npcw = 0; sel3 = 2'b11; sel7 = 2'b11;
    bi1.alu_zero = 1'b1;
    bi1.alu_gt = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
        ndone += int'(bi1.done);
        npcw += int'(bi1.pc_write);
        if (c == 3) sel3 = bi1.branch_sel;
        if (c == 7) sel7 = bi1.branch_sel;
      end
      bi1.start = 1'b1;
      bi1.branch_op = 2'(c);
    end
    bi1.start = 1'b0;
    chk("hold_done", 32'(ndone), 32'd3);
    chk("hold_pcw", 32'(npcw), 32'd3);
    chk("hold_sel3", 32'(sel3), 32'h0);
    chk("hold_sel7", 32'(sel7), 32'h2);
    repeat (2) @(negedge clk);

    // Reset asserted during CMP
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      bi1.start = 1'b0;
    end
    chk("cmp_busy", 32'(bi1.busy), 32'h1);
    chk("cmp_subop", 32'(bi1.alu_op), 32'h6);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bi1.busy), 32'h0);
    chk("arst_done", 32'(bi1.done), 32'h0);
    chk("arst_pcw", 32'(bi1.pc_write), 32'h0);
    chk("arst_alu_op", 32'(bi1.alu_op), 32'h2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0; npcw = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      ndone += int'(bi1.done);
      npcw += int'(bi1.pc_write) + int'(bi1.target_we) + int'(bi1.busy);
    end
    chk("post_rst_done", 32'(ndone), 32'd0);
    chk("post_rst_quiet", 32'(npcw), 32'd0);

`ifdef BRANCH_STATS_EN
    chk("stat_clr_total", 32'(st1_total), 32'd0);
    chk("stat_clr_taken", 32'(st1_taken), 32'd0);
    for (int i = 0; i < 5; i++)
      run_br(1'b0, 2'b00, 16'hFFFF, 16'h0000, twe, bsy, dn, pcw, tkn, sra, sub, srb, sel_bad);
    chk("stat_total", 32'(st1_total), 32'd3);
    chk("stat_taken", 32'(st1_taken), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Multicycle branch sequencer for the MIPS core. It owns the shared ALU for the duration of a conditional branch.
- Computes the branch target first, then performs the rs/rt compare.
- Drives the 2-bit select of the branch-condition mux (EQ, ~EQ, GT, ~GT).
- Issues a single PC-write pulse when the branch is taken.
- Sits between the main control FSM and the PC/ALU datapath.

Parameters:
ALU_LAT, 1, cycles from ALU operand setup to valid flags/result (1..7).
CNT_W, 16, width of the optional statistics counters.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
start  in  1  main FSM requests a branch; sampled only in IDLE
branch_op  in  2  00 BEQ, 01 BNE, 10 BGT, 11 BLE; latched on accepted start
alu_zero  in  1  ALU equal flag
alu_gt  in  1  ALU greater-than flag (signed)
alu_result  in  32  ALU output (target address in TARGET phase)
busy  out  1  high from accepted start until done
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 11 = sign-extended offset << 2
alu_op  out  3  010 ADD, 110 SUB
target_we  out  1  writes alu_result into the branch-target register
branch_sel  out  2  select to the branch-condition mux, equals latched op
pc_write  out  1  one-cycle PC load pulse (PCSource = target register)
done  out  1  one-cycle completion pulse back to main FSM
taken  out  1  valid with done: 1 if branch taken

Behaviour:
Reset (reset=0, async):
- State = IDLE, latency counter = 0, op register = 00.
- All outputs 0, alu_op = 010.

States: IDLE -> TARGET -> T_WAIT -> CMP -> C_WAIT -> RESOLVE -> IDLE.

IDLE:
- busy = 0.
- On start = 1: latch branch_op, go to TARGET.
- start asserted while busy is ignored; it is not queued.

TARGET:
- alu_src_a = 0, alu_src_b = 11, alu_op = ADD.
- Counter loads ALU_LAT-1; go to T_WAIT.

T_WAIT:
- Holds the TARGET ALU controls.
- When counter = 0: target_we = 1 for exactly that cycle, go to CMP. Otherwise decrement.

CMP:
- alu_src_a = 1, alu_src_b = 00, alu_op = SUB.
- Counter loads ALU_LAT-1; go to C_WAIT.

C_WAIT:
- Holds the CMP ALU controls.
- When counter = 0: sample cond into a flop, go to RESOLVE.
- cond by latched op: 00 alu_zero, 01 ~alu_zero, 10 alu_gt, 11 ~alu_gt.

RESOLVE:
- done = 1, taken = cond, pc_write = cond, all for one cycle.
- Return to IDLE. A new start is accepted on the following cycle at the earliest.

Always-on outputs:
- branch_sel = latched op in every state.
- busy = 1 in every non-IDLE state.

Latency:
- Start accepted at cycle 0 gives done at cycle 2*ALU_LAT+3.
- ALU_LAT=1 gives done at cycle 5.

Boundary conditions:
- Reset mid-sequence aborts immediately: no pc_write, no done, target register untouched afterwards.
- ALU_LAT=1: T_WAIT and C_WAIT each last exactly one cycle.
- branch_op changes while busy have no effect.
- Flags are sampled only in the last C_WAIT cycle; glitches earlier are ignored.

Optional Feature:
BRANCH_STATS_EN.

When defined:
- Adds outputs stat_total and stat_taken, each CNT_W bits.
- stat_total increments on each done; stat_taken increments on each done with taken = 1.
- Both saturate at all-ones and clear on reset.

When undefined:
- Ports and logic are absent; the block is otherwise cycle-identical.

Test Plan:
Reset check: reset=0 mid-CMP with ALU_LAT=1 -> busy, pc_write and done drop to 0 asynchronously; after release, state is IDLE and busy=0.

BEQ taken: op=00, alu_zero=1 at C_WAIT -> target_we at cycle 2, done at cycle 5, taken=1, pc_write=1 for one cycle, branch_sel=00 throughout.

BNE not taken: op=01, alu_zero=1 -> done at cycle 5, taken=0, pc_write stays 0.

BLE with ALU_LAT=3: op=11, alu_gt=0 -> target_we at cycle 4, done at cycle 9, taken=1; alu_gt pulsed 1 during the non-final C_WAIT cycles is ignored.

Busy protection: start held high continuously with op toggling each cycle -> exactly one branch per 6-cycle window (ALU_LAT=1); branch_sel equals the op latched at acceptance.

Stats (BRANCH_STATS_EN, CNT_W=2): 5 taken branches -> stat_total=3 and stat_taken=3, saturated.
